// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg
//   Shared encodings and scoreboard entry type for the hazard/forwarding
//   controller of the 5-stage MIPS core.
//   - FWD_*  : operand select encoding driven to the D/E operand muxes
//   - SRC_*  : where a writer's result is produced (ALU in E, DM in M)
//   - TUSE_* : stage in which a source operand is first consumed
//   - sb_entry_t : one in-flight writer {valid, rd, src}
package hazard_ctrl_pkg;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_M     = 2'b01;
  localparam logic [1:0] FWD_W     = 2'b10;

  localparam logic [1:0] SRC_NONE  = 2'd0;
  localparam logic [1:0] SRC_ALU   = 2'd1;
  localparam logic [1:0] SRC_DM    = 2'd2;

  localparam logic [1:0] TUSE_D    = 2'd0;
  localparam logic [1:0] TUSE_E    = 2'd1;
  localparam logic [1:0] TUSE_NONE = 2'd3;

  // Entries hold register indices zero-extended to this width, so any
  // REG_W up to 8 shares the same entry type.
  localparam int SB_REG_W = 8;

  // Scoreboard depth and slot order: index 0 is the newest writer.
  localparam int SB_DEPTH = 3;
  localparam int SB_E     = 0;
  localparam int SB_M     = 1;
  localparam int SB_W     = 2;

  typedef struct packed {
    logic                valid;
    logic [SB_REG_W-1:0] rd;
    logic [1:0]          src;
  } sb_entry_t;

  // Only ALU and DM producers ever reach a register; 3 aliases none.
  function automatic logic src_fwd(input logic [1:0] s);
    return (s == SRC_ALU) || (s == SRC_DM);
  endfunction

  // $0 is hardwired, so it never depends on an in-flight writer.
  function automatic logic sb_match(input logic [SB_REG_W-1:0] x,
                                    input sb_entry_t           e);
    return e.valid && src_fwd(e.src) && (e.rd == x) && (x != '0);
  endfunction

endpackage

// File: rtl/hazard_src_chk.sv
// hazard_src_chk
//   Per-source-operand hazard check against the E/M/W scoreboard.
//   Ports:
//     src_reg     in   REG_W  source register index
//     tuse        in   2      consuming stage (TUSE_*; 2 acts as none)
//     sb_e/m/w    in   entry  scoreboard slots, newest first
//     src_stall   out  1      this operand cannot be satisfied this cycle
//     zero_trans  out  2      D-stage operand select
//     e_trans_nxt out  2      E-stage select to register if D advances
module hazard_src_chk
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] src_reg,
  input  logic [1:0]       tuse,
  input  sb_entry_t        sb_e,
  input  sb_entry_t        sb_m,
  input  sb_entry_t        sb_w,
  output logic             src_stall,
  output logic [1:0]       zero_trans,
  output logic [1:0]       e_trans_nxt
);

  logic [SB_REG_W-1:0] x;
  logic m_e, m_m, m_w;
  logic need_d, need_e;

  assign x      = SB_REG_W'(src_reg);
  assign m_e    = sb_match(x, sb_e);
  assign m_m    = sb_match(x, sb_m);
  assign m_w    = sb_match(x, sb_w);
  assign need_d = (tuse == TUSE_D);
  assign need_e = (tuse == TUSE_E);

  // Branch operands need the value in D: a writer still in E has nothing
  // to offer yet, and a load in M has not read memory yet. E consumers
  // only wait on a load sitting in E.
  assign src_stall = (need_d && (m_e || (m_m && sb_m.src == SRC_DM))) ||
                     (need_e && m_e && sb_e.src == SRC_DM);

  // Newest writer wins. A load in M shadows older writers but cannot
  // forward yet, so the select stays RF (only matters while stalled).
  always_comb begin
    zero_trans = FWD_RF;
    if (m_e)
      zero_trans = FWD_RF;
    else if (m_m)
      zero_trans = (sb_m.src == SRC_ALU) ? FWD_M : FWD_RF;
    else if (m_w)
      zero_trans = FWD_W;
  end

  // Seen from E one cycle later: today's E writer will be in M, today's
  // M writer in W. Today's W writer is already covered by zero_trans.
  always_comb begin
    e_trans_nxt = FWD_RF;
    if (m_e && sb_e.src == SRC_ALU)
      e_trans_nxt = FWD_M;
    else if (m_m)
      e_trans_nxt = FWD_W;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Pipeline hazard / forwarding controller for the 5-stage MIPS core.
//   Tracks writers in E, M and W and produces the stall, D-stage forward
//   selects (combinational) and E-stage forward selects (registered).
//   Ports:
//     clk, rst_n                   clock, synchronous active-low reset
//     id_valid                     D holds a real instruction
//     id_rs/id_rt, *_tuse          D source indices and consuming stage
//     id_wr_en/id_wr_reg/id_res_src  D destination and result source
//     stall                        freeze PC, F/D; bubble into E
//     zero_rs_trans/zero_rt_trans  D-stage operand selects
//     e_rs_trans/e_rt_trans        E-stage operand selects (registered)
//     stall_cnt                    saturating count of stalled cycles
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [1:0]       id_rs_tuse,
  input  logic [1:0]       id_rt_tuse,
  input  logic             id_wr_en,
  input  logic [REG_W-1:0] id_wr_reg,
  input  logic [1:0]       id_res_src,
  output logic             stall,
  output logic [1:0]       zero_rs_trans,
  output logic [1:0]       zero_rt_trans,
  output logic [1:0]       e_rs_trans,
  output logic [1:0]       e_rt_trans,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int NUM_SRC = 2; // 0 = rs, 1 = rt

  sb_entry_t                     sb [SB_DEPTH];
  sb_entry_t                     sb_new;
  logic [NUM_SRC-1:0][REG_W-1:0] src_reg;
  logic [NUM_SRC-1:0][1:0]       src_tuse;
  logic [NUM_SRC-1:0]            src_stall;
  logic [NUM_SRC-1:0][1:0]       zero_trans;
  logic [NUM_SRC-1:0][1:0]       e_trans_nxt;
  logic [NUM_SRC-1:0][1:0]       e_trans_q;

  assign src_reg  = {id_rt, id_rs};
  assign src_tuse = {id_rt_tuse, id_rs_tuse};

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    hazard_src_chk #(.REG_W(REG_W)) u_chk (
      .src_reg     (src_reg[i]),
      .tuse        (src_tuse[i]),
      .sb_e        (sb[SB_E]),
      .sb_m        (sb[SB_M]),
      .sb_w        (sb[SB_W]),
      .src_stall   (src_stall[i]),
      .zero_trans  (zero_trans[i]),
      .e_trans_nxt (e_trans_nxt[i])
    );
  end

  // rs == rt yields identical per-source results; the OR counts it once.
  assign stall         = id_valid && (|src_stall);
  assign zero_rs_trans = zero_trans[0];
  assign zero_rt_trans = zero_trans[1];
  assign e_rs_trans    = e_trans_q[0];
  assign e_rt_trans    = e_trans_q[1];

  // A stalled or empty D slot enters E as a bubble. Writes to $0 and
  // writers without a forwardable result never create an entry.
  always_comb begin
    sb_new = '0;
    if (id_valid && !stall) begin
      sb_new.valid = id_wr_en && (id_wr_reg != '0) && src_fwd(id_res_src);
      sb_new.rd    = SB_REG_W'(id_wr_reg);
      sb_new.src   = id_res_src;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SB_DEPTH; i++) sb[i] <= '0;
      e_trans_q <= {NUM_SRC{FWD_RF}};
      stall_cnt <= '0;
    end else begin
      for (int i = SB_DEPTH - 1; i > 0; i--) sb[i] <= sb[i-1];
      sb[SB_E] <= sb_new;

      if (stall || !id_valid)
        e_trans_q <= {NUM_SRC{FWD_RF}};
      else
        e_trans_q <= e_trans_nxt;

      if (stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  localparam int REG_W   = 5;
  localparam int CNT_W   = 3;  // small so saturation is reachable
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             id_valid = 1'b0;
  logic [REG_W-1:0] id_rs = '0, id_rt = '0, id_wr_reg = '0;
  logic [1:0]       id_rs_tuse = TUSE_NONE, id_rt_tuse = TUSE_NONE;
  logic             id_wr_en = 1'b0;
  logic [1:0]       id_res_src = SRC_NONE;
  logic             stall;
  logic [1:0]       zero_rs_trans, zero_rt_trans, e_rs_trans, e_rt_trans;
  logic [CNT_W-1:0] stall_cnt;

  hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rs_tuse(id_rs_tuse), .id_rt_tuse(id_rt_tuse),
    .id_wr_en(id_wr_en), .id_wr_reg(id_wr_reg), .id_res_src(id_res_src),
    .stall(stall), .zero_rs_trans(zero_rs_trans), .zero_rt_trans(zero_rt_trans),
    .e_rs_trans(e_rs_trans), .e_rt_trans(e_rt_trans), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [1:0] rs;
    logic [1:0] rt;
  } e_exp_t;

  e_exp_t q_e[$];
  int     n_tests = 0;
  int     n_fail  = 0;
  int     model_cnt = 0;
  logic   rst_drive = 1'b1;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // E selects appear one edge after their D cycle.
  task automatic pop_e();
    e_exp_t e;
    if (q_e.size() == 0) return;
    e = q_e.pop_front();
    cmp({e.tag, "/e_rs"}, 32'(e_rs_trans), 32'(e.rs));
    cmp({e.tag, "/e_rt"}, 32'(e_rt_trans), 32'(e.rt));
  endtask

  task automatic cycle(input string tag, input logic v,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic [1:0] rs_tu, input logic [1:0] rt_tu,
                       input logic we, input logic [4:0] wr, input logic [1:0] src,
                       input logic x_stall, input logic [1:0] x_zrs, input logic [1:0] x_zrt,
                       input logic [1:0] x_ers, input logic [1:0] x_ert);
    e_exp_t e;
    @(negedge clk);
    pop_e();
    cmp({tag, "/cnt"}, 32'(stall_cnt), 32'(model_cnt));
    rst_n      = rst_drive;
    id_valid   = v;
    id_rs      = rs;
    id_rt      = rt;
    id_rs_tuse = rs_tu;
    id_rt_tuse = rt_tu;
    id_wr_en   = we;
    id_wr_reg  = wr;
    id_res_src = src;
    #1;
    cmp({tag, "/stall"}, 32'(stall), 32'(x_stall));
    cmp({tag, "/z_rs"}, 32'(zero_rs_trans), 32'(x_zrs));
    cmp({tag, "/z_rt"}, 32'(zero_rt_trans), 32'(x_zrt));
    e.tag = tag;
    e.rs  = rst_drive ? x_ers : FWD_RF;
    e.rt  = rst_drive ? x_ert : FWD_RF;
    q_e.push_back(e);
    if (!rst_drive) model_cnt = 0;
    else if (x_stall && model_cnt != CNT_MAX) model_cnt++;
  endtask

  task automatic nop(input string tag);
    cycle(tag, 1'b1, 5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 1'b0, 5'd0, SRC_NONE,
          1'b0, FWD_RF, FWD_RF, FWD_RF, FWD_RF);
  endtask

  task automatic drain();
    nop("nop"); nop("nop"); nop("nop");
  endtask

  initial begin
    e_exp_t r;
    // hold reset for two edges, then the first E pop checks reset values
    repeat (2) @(posedge clk);
    rst_n = 1'b1;
    r.tag = "reset"; r.rs = FWD_RF; r.rt = FWD_RF;
    q_e.push_back(r);
    model_cnt = 0;
    nop("rst");

    // lw $8 ; beq $8,$9 : two stall cycles, then W forward
    cycle("a_lw",   1, 0, 0, TUSE_NONE, TUSE_NONE, 1, 8, SRC_DM,   0, FWD_RF, FWD_RF, FWD_RF, FWD_RF);
    cycle("a_beq1", 1, 8, 9, TUSE_D, TUSE_D, 0, 0, SRC_NONE,       1, FWD_RF, FWD_RF, FWD_RF, FWD_RF);
    cycle("a_beq2", 1, 8, 9, TUSE_D, TUSE_D, 0, 0, SRC_NONE,       1, FWD_RF, FWD_RF, FWD_RF, FWD_RF);
    cycle("a_beq3", 1, 8, 9, TUSE_D, TUSE_D, 0, 0, SRC_NONE,       0, FWD_W,  FWD_RF, FWD_RF, FWD_RF);
    drain();

    // addu $8 ; beq $8,$8 : one stall, then M forward on both
    cycle("b_addu", 1, 1, 2, TUSE_E, TUSE_E, 1, 8, SRC_ALU,        0, FWD_RF, FWD_RF, FWD_RF, FWD_RF);
    cycle("b_beq1", 1, 8, 8, TUSE_D, TUSE_D, 0, 0, SRC_NONE,       1, FWD_RF, FWD_RF, FWD_RF, FWD_RF);
    cycle("b_beq2", 1, 8, 8, TUSE_D, TUSE_D, 0, 0, SRC_NONE,       0, FWD_M,  FWD_M,  FWD_W,  FWD_W);
    drain();

    // addu ; nop ; beq  and  addu ; nop ; nop ; beq
    cycle("c_addu", 1, 1, 2, TUSE_E, TUSE_E, 1, 8, SRC_ALU,        0, FWD_RF, FWD_RF, FWD_RF, FWD_RF);
    nop("c_nop");
    cycle("c_beq",  1, 8, 9, TUSE_D, TUSE_D, 0, 0, SRC_NONE,       0, FWD_M,  FWD_RF, FWD_W,  FWD_RF);
    drain();
    cycle("c2_addu", 1, 1, 2, TUSE_E, TUSE_E, 1, 8, SRC_ALU,       0, FWD_RF, FWD_RF, FWD_RF, FWD_RF);
    nop("c2_nop1");
    nop("c2_nop2");
    cycle("c2_beq", 1, 8, 9, TUSE_D, TUSE_D, 0, 0, SRC_NONE,       0, FWD_W,  FWD_RF, FWD_RF, FWD_RF);
    drain();

    // lw $8 ; addu $3,$8 (E consumer): one stall, then E select = W
    cycle("d_lw",    1, 0, 0, TUSE_NONE, TUSE_NONE, 1, 8, SRC_DM,  0, FWD_RF, FWD_RF, FWD_RF, FWD_RF);
    cycle("d_addu1", 1, 8, 0, TUSE_E, TUSE_E, 1, 3, SRC_ALU,       1, FWD_RF, FWD_RF, FWD_RF, FWD_RF);
    cycle("d_addu2", 1, 8, 0, TUSE_E, TUSE_E, 1, 3, SRC_ALU,       0, FWD_RF, FWD_RF, FWD_W,  FWD_RF);
    drain();
    // addu $8 ; addu $3,$8 : no stall, E select = M
    cycle("d2_addu", 1, 1, 2, TUSE_E, TUSE_E, 1, 8, SRC_ALU,       0, FWD_RF, FWD_RF, FWD_RF, FWD_RF);
    cycle("d2_use",  1, 8, 0, TUSE_E, TUSE_E, 1, 3, SRC_ALU,       0, FWD_RF, FWD_RF, FWD_M,  FWD_RF);
    drain();

    // $0 writer, reserved src/tuse encodings, invalid D slot
    cycle("e_w0",    1, 0, 0, TUSE_NONE, TUSE_NONE, 1, 0, SRC_DM,  0, FWD_RF, FWD_RF, FWD_RF, FWD_RF);
    cycle("e_beq0",  1, 0, 0, TUSE_D, TUSE_D, 0, 0, SRC_NONE,      0, FWD_RF, FWD_RF, FWD_RF, FWD_RF);
    cycle("e_beq0b", 1, 0, 0, TUSE_D, TUSE_D, 0, 0, SRC_NONE,      0, FWD_RF, FWD_RF, FWD_RF, FWD_RF);
    cycle("e_src3",  1, 0, 0, TUSE_NONE, TUSE_NONE, 1, 9, 2'd3,    0, FWD_RF, FWD_RF, FWD_RF, FWD_RF);
    cycle("e_beq9",  1, 9, 9, TUSE_D, TUSE_D, 0, 0, SRC_NONE,      0, FWD_RF, FWD_RF, FWD_RF, FWD_RF);
    cycle("e_lw9",   1, 0, 0, TUSE_NONE, TUSE_NONE, 1, 9, SRC_DM,  0, FWD_RF, FWD_RF, FWD_RF, FWD_RF);
    cycle("e_tu2",   1, 9, 9, 2'd2, 2'd2, 0, 0, SRC_NONE,          0, FWD_RF, FWD_RF, FWD_RF, FWD_RF);
    cycle("e_inv",   0, 0, 0, TUSE_NONE, TUSE_NONE, 1, 9, SRC_ALU, 0, FWD_RF, FWD_RF, FWD_RF, FWD_RF);
    cycle("e_chkinv", 1, 9, 0, TUSE_D, TUSE_NONE, 0, 0, SRC_NONE,  0, FWD_W,  FWD_RF, FWD_RF, FWD_RF);
    drain();

    // repeated load-use branches push the counter into saturation
    for (int k = 0; k < 2; k++) begin
      cycle("g_lw",   1, 0, 0, TUSE_NONE, TUSE_NONE, 1, 8, SRC_DM, 0, FWD_RF, FWD_RF, FWD_RF, FWD_RF);
      cycle("g_beq1", 1, 8, 9, TUSE_D, TUSE_D, 0, 0, SRC_NONE,     1, FWD_RF, FWD_RF, FWD_RF, FWD_RF);
      cycle("g_beq2", 1, 8, 9, TUSE_D, TUSE_D, 0, 0, SRC_NONE,     1, FWD_RF, FWD_RF, FWD_RF, FWD_RF);
      cycle("g_beq3", 1, 8, 9, TUSE_D, TUSE_D, 0, 0, SRC_NONE,     0, FWD_W,  FWD_RF, FWD_RF, FWD_RF);
    end
    nop("g_sat");
    cmp("g_sat/cnt_max", 32'(stall_cnt), 32'(CNT_MAX));
    drain();

    // reset during the second stall cycle of a load-use branch
    cycle("f_lw",   1, 0, 0, TUSE_NONE, TUSE_NONE, 1, 8, SRC_DM,   0, FWD_RF, FWD_RF, FWD_RF, FWD_RF);
    cycle("f_beq1", 1, 8, 9, TUSE_D, TUSE_D, 0, 0, SRC_NONE,       1, FWD_RF, FWD_RF, FWD_RF, FWD_RF);
    rst_drive = 1'b0;
    cycle("f_beq2", 1, 8, 9, TUSE_D, TUSE_D, 0, 0, SRC_NONE,       1, FWD_RF, FWD_RF, FWD_RF, FWD_RF);
    rst_drive = 1'b1;
    cycle("f_after", 1, 8, 9, TUSE_D, TUSE_D, 0, 0, SRC_NONE,      0, FWD_RF, FWD_RF, FWD_RF, FWD_RF);
    nop("f_end");

    @(negedge clk);
    pop_e();
    cmp("end/cnt", 32'(stall_cnt), 32'(model_cnt));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
